// File: rtl/bits_framer.sv
// bits_framer: preamble hunt + fixed-length frame assembly with timeout abort.
// Define BITS_FRAMER_CRC16_EN to add the serial CRC-16/CCITT residue check on out_err.
module bits_framer #(
  parameter int PREAMBLE_LEN = 6,
  parameter logic [PREAMBLE_LEN-1:0] PREAMBLE = 6'b101011,
  parameter int PAYLOAD_BITS = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    arm,
  input  logic                    in_dat,
  input  logic                    in_vld,
  output logic [PAYLOAD_BITS-1:0] frame_dat,
  output logic                    out_vld,
  output logic                    out_err,
  output logic                    out_timeout,
  output logic                    busy
);
  localparam int BW = $clog2(PAYLOAD_BITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [BW-1:0] LAST = BW'(PAYLOAD_BITS - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [FW-1:0] FULL = FW'(PREAMBLE_LEN);

  typedef enum logic [1:0] {IDLE, HUNT, COLLECT, DONE} state_t;
  state_t state;
  logic [PREAMBLE_LEN-1:0] pre_sr, pre_nxt;
  logic [FW-1:0] fill, fill_nxt;
  logic [BW-1:0] bit_cnt;
  logic [TW-1:0] timer;
  logic [PAYLOAD_BITS-1:0] frame_sr, frame_nxt;
  logic match, last, expire, crc_bad;

  assign pre_nxt = {pre_sr[PREAMBLE_LEN-2:0], in_dat};
  assign fill_nxt = (fill == FULL) ? FULL : fill + 1'b1;
  assign match = in_vld && fill_nxt == FULL && pre_nxt == PREAMBLE;
  assign frame_nxt = {frame_sr[PAYLOAD_BITS-2:0], in_dat};
  assign last = in_vld && bit_cnt == LAST;
  assign expire = timer == TLAST;

`ifdef BITS_FRAMER_CRC16_EN
  logic [15:0] crc, crc_nxt;
  assign crc_nxt = {crc[14:0], 1'b0} ^ ((crc[15] ^ in_dat) ? 16'h1021 : 16'h0000);
  assign crc_bad = crc_nxt != 16'h1D0F;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) crc <= 16'hFFFF;
    else if (state == IDLE && arm) crc <= 16'hFFFF;
    else if (state == COLLECT && in_vld) crc <= crc_nxt;
  end
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pre_sr <= '0;
      fill <= '0;
      bit_cnt <= '0;
      timer <= '0;
      frame_sr <= '0;
      frame_dat <= '0;
      out_vld <= 1'b0;
      out_err <= 1'b0;
      out_timeout <= 1'b0;
      busy <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      out_timeout <= 1'b0;
      case (state)
        IDLE: if (arm) begin
          state <= HUNT;
          busy <= 1'b1;
          pre_sr <= '0;
          fill <= '0;
          bit_cnt <= '0;
          timer <= '0;
        end
        HUNT: begin
          if (in_vld) begin
            pre_sr <= pre_nxt;
            fill <= fill_nxt;
          end
          if (match) begin
            state <= COLLECT;
            timer <= '0;
          end else if (expire) begin
            state <= IDLE;
            busy <= 1'b0;
            out_timeout <= 1'b1;
          end else timer <= timer + 1'b1;
        end
        COLLECT: begin
          // an accepted bit restarts the timer, so it always beats expiry
          if (in_vld) begin
            frame_sr <= frame_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            timer <= '0;
          end else if (expire) begin
            state <= IDLE;
            busy <= 1'b0;
            out_timeout <= 1'b1;
          end else timer <= timer + 1'b1;
          if (last) begin
            state <= DONE;
            frame_dat <= frame_nxt;
            out_err <= crc_bad;
            out_vld <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bits_framer.sv
// tb_bits_framer: directed checks of preamble lock, framing, CRC flag, timeout, reset and arm handling.
module tb_bits_framer;
  logic clk = 1'b0, rst, arm, in_dat, in_vld;
  logic [31:0] frame_dat;
  logic out_vld, out_err, out_timeout, busy;
  int checks = 0, errors = 0, vld_cnt = 0, vld_base;
  logic [15:0] c;
  logic [31:0] good, bad;
  logic exp_bad_err;

  bits_framer dut (
    .clk(clk), .rst(rst), .arm(arm), .in_dat(in_dat), .in_vld(in_vld),
    .frame_dat(frame_dat), .out_vld(out_vld), .out_err(out_err),
    .out_timeout(out_timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (out_vld) vld_cnt <= vld_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      repeat (gap) tick();
      in_dat = v[i];
      in_vld = 1'b1;
      tick();
      in_vld = 1'b0;
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] ci, input logic [31:0] d, input int n);
    logic [15:0] r = ci;
    for (int i = n - 1; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  initial begin
    rst = 1'b1; arm = 1'b0; in_dat = 1'b0; in_vld = 1'b0;
    repeat (2) tick();
    chk("rst_frame", frame_dat, 32'h0);
    chk("rst_vld", {31'b0, out_vld}, 32'h0);
    chk("rst_err", {31'b0, out_err}, 32'h0);
    chk("rst_to", {31'b0, out_timeout}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    rst = 1'b0;
    tick();

    // basic frame with one-cycle gaps
    do_arm();
    chk("arm_busy", {31'b0, busy}, 32'h1);
    send_bits(32'h2B, 6, 1);
    send_bits(32'hDEADBEEF, 32, 1);
    chk("f1_vld", {31'b0, out_vld}, 32'h1);
    chk("f1_dat", frame_dat, 32'hDEADBEEF);
`ifdef BITS_FRAMER_CRC16_EN
    chk("f1_err", {31'b0, out_err}, {31'b0, crc_upd(16'hFFFF, 32'hDEADBEEF, 32) != 16'h1D0F});
`else
    chk("f1_err", {31'b0, out_err}, 32'h0);
`endif
    chk("f1_done_busy", {31'b0, busy}, 32'h1);
    tick();
    chk("f1_vld_drop", {31'b0, out_vld}, 32'h0);
    chk("f1_busy_drop", {31'b0, busy}, 32'h0);
    chk("f1_vld_cnt", vld_cnt, 32'd1);

    // noise then split preamble, back-to-back bits
    do_arm();
    send_bits(32'h6, 4, 0);
    send_bits(32'h5, 3, 0);
    repeat (3) tick();
    send_bits(32'h3, 3, 0);
    send_bits(32'h13579BDF, 32, 0);
    chk("f2_vld", {31'b0, out_vld}, 32'h1);
    chk("f2_dat", frame_dat, 32'h13579BDF);
    tick();

    // payload plus complemented CRC, then corrupted payload
    c = crc_upd(16'hFFFF, 32'h1234, 16);
    good = {16'h1234, ~c};
    bad = {16'h1235, ~c};
`ifdef BITS_FRAMER_CRC16_EN
    exp_bad_err = 1'b1;
`else
    exp_bad_err = 1'b0;
`endif
    do_arm();
    send_bits(32'h2B, 6, 0);
    send_bits(good, 32, 0);
    chk("crc_good_vld", {31'b0, out_vld}, 32'h1);
    chk("crc_good_dat", frame_dat, good);
    chk("crc_good_err", {31'b0, out_err}, 32'h0);
    tick();
    do_arm();
    send_bits(32'h2B, 6, 0);
    send_bits(bad, 32, 0);
    chk("crc_bad_dat", frame_dat, bad);
    chk("crc_bad_err", {31'b0, out_err}, {31'b0, exp_bad_err});
    repeat (3) tick();
    chk("crc_err_hold", {31'b0, out_err}, {31'b0, exp_bad_err});

    // timeout in HUNT with no input
    vld_base = vld_cnt;
    do_arm();
    repeat (4095) tick();
    chk("to_pre_busy", {31'b0, busy}, 32'h1);
    chk("to_pre_pulse", {31'b0, out_timeout}, 32'h0);
    tick();
    chk("to_pulse", {31'b0, out_timeout}, 32'h1);
    chk("to_busy", {31'b0, busy}, 32'h0);
    chk("to_frame", frame_dat, bad);
    chk("to_err", {31'b0, out_err}, {31'b0, exp_bad_err});
    tick();
    chk("to_pulse_drop", {31'b0, out_timeout}, 32'h0);
    chk("to_no_vld", vld_cnt, vld_base);

    // reset mid-frame, then a clean frame
    do_arm();
    send_bits(32'h2B, 6, 0);
    send_bits(32'h3FF, 10, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_frame", frame_dat, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_no_vld", vld_cnt, vld_base);
    chk("mid_rst_no_to", {31'b0, out_timeout}, 32'h0);
    do_arm();
    send_bits(32'h2B, 6, 0);
    send_bits(32'hCAFEF00D, 32, 0);
    chk("rearm_dat", frame_dat, 32'hCAFEF00D);
    chk("rearm_vld", {31'b0, out_vld}, 32'h1);
    tick();
    chk("rearm_vld_cnt", vld_cnt, vld_base + 1);

    // arm during COLLECT and DONE ignored; arm right after DONE accepted
    do_arm();
    send_bits(32'h2B, 6, 0);
    send_bits(32'hA5A5, 16, 0);
    arm = 1'b1;
    send_bits(32'h0F0F, 16, 0);
    chk("armc_dat", frame_dat, 32'hA5A50F0F);
    chk("armc_vld", {31'b0, out_vld}, 32'h1);
    tick();
    chk("armd_ignored", {31'b0, busy}, 32'h0);
    tick();
    arm = 1'b0;
    chk("arm_after_done", {31'b0, busy}, 32'h1);
    chk("armc_vld_cnt", vld_cnt, vld_base + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bits_framer.md
# bits_framer

Frame assembler directly downstream of the bits detector in the RFID reader receive chain. Consumes the detected bit stream (one bit per `in_vld` pulse), hunts for a parameterised preamble after being armed, then collects a fixed-length tag reply into a parallel word. Each completed frame is presented with a one-cycle valid pulse and an optional CRC-16 error flag. A timeout returns the block to idle when no tag answers.

## Interface
- `PREAMBLE_LEN`, 6, number of preamble bits matched.
- `PREAMBLE`, 6'b101011, preamble pattern, first-received bit in the MSB.
- `PAYLOAD_BITS`, 32, reply length excluding the preamble; must be ≥17 when CRC is compiled in.
- `TIMEOUT`, 4096, idle clock cycles tolerated in HUNT/COLLECT before abort; ≥2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `arm` in 1: single-cycle request to start a frame search; honoured only in IDLE.
- `in_dat` in 1: detected bit from the bits detector.
- `in_vld` in 1: `in_dat` qualifier, single-cycle pulse per bit.
- `frame_dat` out PAYLOAD_BITS: last completed frame; first payload bit in the MSB.
- `out_vld` out 1: one-cycle pulse when `frame_dat` is updated.
- `out_err` out 1: CRC failure for the current frame; valid with `out_vld` and held until the next `out_vld`.
- `out_timeout` out 1: one-cycle pulse on timeout abort.
- `busy` out 1: high in HUNT, COLLECT and DONE.

## Operation
- States: IDLE, HUNT, COLLECT, DONE.
- IDLE → HUNT on `arm`. Entry clears the preamble shift register, the fill counter, the bit counter, the timer and the CRC (preset 0xFFFF).
- HUNT: each `in_vld` shifts `in_dat` into the PREAMBLE_LEN shift register, LSB side.
  - The fill counter saturates at PREAMBLE_LEN.
  - A match is evaluated on the post-shift value, and only when the fill count including this bit is ≥ PREAMBLE_LEN.
  - On a match, move to COLLECT on the same edge.
- COLLECT: each `in_vld` shifts `in_dat` into the frame shift register, LSB side; earlier bits move toward the MSB. The bit counter increments.
  - The bit arriving with count == PAYLOAD_BITS-1 completes the frame; move to DONE.
  - `frame_dat` is loaded from the assembled word on that edge.
- DONE: lasts exactly one cycle, then IDLE. `out_vld` is registered high during DONE.
- Timer: counts clock cycles in HUNT and COLLECT. It is cleared on entry to either state and on every `in_vld` accepted in COLLECT; `in_vld` in HUNT does not clear it.
  - When the timer reaches TIMEOUT-1, move to IDLE and assert `out_timeout` for one cycle on that transition.
  - `frame_dat` and `out_err` are untouched.
- Simultaneous `in_vld` and timer expiry: the bit is accepted. A preamble match or frame completion on that edge takes priority, and no timeout is reported.
- `arm` outside IDLE is ignored. `arm` during DONE is ignored; there is no queuing.
- Widths: bit counter `$clog2(PAYLOAD_BITS+1)`; timer `$clog2(TIMEOUT+1)`; fill counter `$clog2(PREAMBLE_LEN+1)`. All counters are unsigned and never wrap.

## Timing
- Reset values: `frame_dat` = 0, `out_vld` = 0, `out_err` = 0, `out_timeout` = 0, `busy` = 0, state = IDLE.
- Reset mid-frame aborts immediately. No `out_vld` or `out_timeout` is produced.
- `busy` rises the cycle after `arm` in IDLE.
- Latency: `out_vld` is high the cycle after the clock edge that samples the final payload `in_vld`. `busy` falls one cycle later.
- Back-to-back `in_vld` on consecutive cycles is supported in all states.
- Minimum re-arm: `arm` in the cycle after DONE is accepted.

## Configuration
- Macro: `BITS_FRAMER_CRC16_EN`.
- Defined:
  - CRC-16/CCITT (poly 0x1021, preset 0xFFFF, MSB-first) is updated serially on every COLLECT bit.
  - The last 16 payload bits are the transmitted complemented CRC.
  - `out_err` = (final register ≠ residue 0x1D0F), registered with `out_vld`.
- Undefined: no CRC logic is generated and `out_err` is tied to 0.

## Test plan
- Arm, send 101011, then 32 bits 0xDEADBEEF with 1-cycle gaps: one `out_vld`, `frame_dat` = 0xDEADBEEF. Without the CRC macro, `out_err` = 0.
- Noise 0110 before the preamble, with the preamble split across a 3-cycle `in_vld` gap: still locks, and `frame_dat` equals the payload sent after the preamble.
- With the CRC macro: payload 0x1234 followed by its bench-computed complemented CRC-16 gives `out_err` = 0. Flipping payload bit 0 gives `out_err` = 1.
- Arm with no input for 4096 cycles: `out_timeout` pulses once at cycle 4096 after HUNT entry, state returns to IDLE, `frame_dat` is unchanged.
- Assert `rst` after 10 payload bits, then re-arm and send a full frame: no output for the aborted frame; the second frame is correct.
- `arm` pulsed during COLLECT and during DONE: ignored. `arm` the cycle after DONE: `busy` rises the following cycle.
